wb_ex_ctrl: RTL and testbench
=============================

// Module: wb_ex_ctrl
// PURPOSE
//  Write-back exception/return commit controller; the initiator side of the CSR
//  exception interface (wb_ex, wb_ecode/esubcode, wb_csr_pc, wb_vaddr, ertn_flush).
//  Prioritises the WB instruction's exception flags and pending interrupts, pulses
//  the CSR update, flushes the pipeline and hands the redirect PC to fetch.
// PARAMETERS
//  DRAIN_CYCLES  2  cycles commit stays blocked after the redirect is accepted (0 = none)
// PORTS
//  clk            in   1   clock
//  resetn         in   1   reset, asynchronous, active-low
//  wb_valid       in   1   WB holds a valid instruction
//  wb_pc          in   32  PC of the WB instruction
//  wb_vaddr_in    in   32  data address of the WB load/store
//  wb_ex_adef     in   1   fetch address error
//  wb_ex_ine      in   1   instruction not exist
//  wb_ex_sys      in   1   syscall
//  wb_ex_brk      in   1   break
//  wb_ex_ale      in   1   address misaligned
//  wb_ertn        in   1   WB instruction is ertn
//  has_int        in   1   CSR: |(ESTAT.IS & ECFG.LIE) & CRMD.IE
//  ex_entry       in   32  CSR exception entry {EENTRY.VA,6'b0}
//  ertn_entry     in   32  CSR ERA value
//  commit_en      out  1   WB may write GPR/CSR this cycle
//  wb_ex          out  1   CSR: take exception (1-cycle pulse)
//  ertn_flush     out  1   CSR: exception return (1-cycle pulse)
//  wb_ecode       out  6   CSR: exception code
//  wb_esubcode    out  9   CSR: exception subcode
//  wb_csr_pc      out  32  CSR: ERA value
//  wb_vaddr       out  32  CSR: bad virtual address
//  pipe_flush     out  1   kill IF..MEM (1-cycle pulse)
//  redirect_valid out  1   fetch redirect request
//  redirect_pc    out  32  fetch redirect target
//  redirect_ready in   1   fetch accepts redirect
// BEHAVIOUR
//  - Reset (async): state=RUN, drain counter=0, every registered output 0.
//  - commit_en = (state==RUN) & wb_valid & ~event (combinational); 0 when wb_valid=0.
//  - event = (state==RUN) & wb_valid & (has_int|adef|ine|sys|brk|ale|ertn), sampled at T.
//  - Priority: INT(0x00) > ADEF(0x08,sub 0) > INE(0x0D) > SYS(0x0B) > BRK(0x0C) >
//    ALE(0x09) > ertn. Any exception/interrupt suppresses ertn. esubcode=0 except ADEF.
//  - wb_csr_pc=wb_pc (faulting instruction does not commit); wb_vaddr=wb_pc for ADEF,
//    wb_vaddr_in for ALE, 0 otherwise.
//  - Latency: event at edge T -> at T+1 exactly one of wb_ex/ertn_flush high for one
//    cycle, pipe_flush high one cycle, redirect_valid=1, redirect_pc=ex_entry or
//    ertn_entry as sampled at T; ecode/sub/pc/vaddr registered, stable while non-RUN.
//  - FSM: RUN -event-> FLUSH; FLUSH -ready-> DRAIN (or RUN if DRAIN_CYCLES=0);
//    FLUSH -~ready-> REDIR; REDIR holds redirect_valid/pc constant until ready;
//    DRAIN counts DRAIN_CYCLES then RUN. redirect_valid drops the cycle after handshake.
//  - Non-RUN states: commit_en=0, all WB flags and has_int ignored (no nested event).
//  - has_int with wb_valid=0: not taken; waits for next valid WB instruction.
//  - Reset asserted mid-FLUSH/REDIR/DRAIN: immediate return to reset values, no pulse.
// STRUCTURE
//  - defines.vh: ECODE_INT/ADEF/ALE/SYS/BRK/INE, ESUBCODE_ADEF, state encodings.
//  - Sub-module ex_prio_enc: combinational flags+has_int -> {take, is_ertn, ecode,
//    esubcode, vaddr_sel}; FSM, counter and output registers stay here.
// TESTING
//  - syscall at pc=0x1c000100, ex_entry=0x1c008000 -> T+1 wb_ex=1, ecode=0x0B,
//    wb_csr_pc=0x1c000100, redirect_pc=0x1c008000, commit_en=0 at T.
//  - ale+has_int, vaddr=0x00000003 -> ecode=0x00, wb_vaddr=0; no second pulse.
//  - ertn, ertn_entry=0x1c000104 -> ertn_flush pulse, wb_ex=0, redirect_pc=0x1c000104.
//  - redirect_ready low 3 cycles -> redirect_valid/pc held 3+1 cycles, then DRAIN
//    2 cycles with commit_en=0, then RUN.
//  - adef at pc=0x1c000002 -> ecode=0x08, esub=0, wb_vaddr=0x1c000002.
//  - resetn low in REDIR -> all outputs 0 immediately; after release, first valid
//    non-excepting instruction gets commit_en=1.

Source files
------------

// File: rtl/wb_ex_ctrl_pkg.sv
// Shared definitions for the write-back exception/return commit controller:
// exception codes, controller states and the bad-vaddr source selector.
package wb_ex_ctrl_pkg;

    localparam logic [5:0] ECODE_INT  = 6'h00;
    localparam logic [5:0] ECODE_ADEF = 6'h08;
    localparam logic [5:0] ECODE_ALE  = 6'h09;
    localparam logic [5:0] ECODE_SYS  = 6'h0B;
    localparam logic [5:0] ECODE_BRK  = 6'h0C;
    localparam logic [5:0] ECODE_INE  = 6'h0D;

    localparam logic [8:0] ESUBCODE_ADEF = 9'h000;
    localparam logic [8:0] ESUBCODE_NONE = 9'h000;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_FLUSH = 2'd1,
        ST_REDIR = 2'd2,
        ST_DRAIN = 2'd3
    } ctrl_state_e;

    typedef enum logic [1:0] {
        VA_ZERO = 2'd0,
        VA_PC   = 2'd1,
        VA_DATA = 2'd2
    } vaddr_sel_e;

    // Picks the value reported as the bad virtual address.
    function automatic logic [31:0] sel_vaddr(input vaddr_sel_e sel,
                                              input logic [31:0] pc,
                                              input logic [31:0] data);
        logic [31:0] res;
        case (sel)
            VA_PC:   res = pc;
            VA_DATA: res = data;
            VA_ZERO: res = 32'h0000_0000;
            default: res = 32'h0000_0000;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/wb_ex_ctrl_prio_enc.sv
// Combinational priority encoder: folds the WB exception flags, pending
// interrupt and ertn into a single decision plus the CSR code/subcode.
module wb_ex_ctrl_prio_enc
    import wb_ex_ctrl_pkg::*;
(
    input  logic       has_int,
    input  logic       ex_adef,
    input  logic       ex_ine,
    input  logic       ex_sys,
    input  logic       ex_brk,
    input  logic       ex_ale,
    input  logic       ertn,
    output logic       take,
    output logic       is_ertn,
    output logic [5:0] ecode,
    output logic [8:0] esubcode,
    output vaddr_sel_e vaddr_sel
);

    // Interrupt first, then the instruction's own faults; ertn only when nothing else fires.
    always_comb begin
        take      = 1'b1;
        is_ertn   = 1'b0;
        ecode     = ECODE_INT;
        esubcode  = ESUBCODE_NONE;
        vaddr_sel = VA_ZERO;
        if (has_int) begin
            ecode = ECODE_INT;
        end else if (ex_adef) begin
            ecode     = ECODE_ADEF;
            esubcode  = ESUBCODE_ADEF;
            vaddr_sel = VA_PC;
        end else if (ex_ine) begin
            ecode = ECODE_INE;
        end else if (ex_sys) begin
            ecode = ECODE_SYS;
        end else if (ex_brk) begin
            ecode = ECODE_BRK;
        end else if (ex_ale) begin
            ecode     = ECODE_ALE;
            vaddr_sel = VA_DATA;
        end else begin
            take    = 1'b0;
            is_ertn = ertn;
        end
    end

endmodule

// File: rtl/wb_ex_ctrl.sv
// Write-back exception/return commit controller. Detects an exception,
// interrupt or ertn on the WB instruction, pulses the CSR update and the
// pipeline flush, then holds the fetch redirect until it is accepted and
// keeps commit blocked for a short drain window.
module wb_ex_ctrl
    import wb_ex_ctrl_pkg::*;
#(
    parameter int unsigned DRAIN_CYCLES = 2
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        wb_valid,
    input  logic [31:0] wb_pc,
    input  logic [31:0] wb_vaddr_in,
    input  logic        wb_ex_adef,
    input  logic        wb_ex_ine,
    input  logic        wb_ex_sys,
    input  logic        wb_ex_brk,
    input  logic        wb_ex_ale,
    input  logic        wb_ertn,
    input  logic        has_int,
    input  logic [31:0] ex_entry,
    input  logic [31:0] ertn_entry,
    output logic        commit_en,
    output logic        wb_ex,
    output logic        ertn_flush,
    output logic [5:0]  wb_ecode,
    output logic [8:0]  wb_esubcode,
    output logic [31:0] wb_csr_pc,
    output logic [31:0] wb_vaddr,
    output logic        pipe_flush,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    input  logic        redirect_ready
);

    localparam int unsigned CNT_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [CNT_W-1:0] DRAIN_LOAD = CNT_W'(DRAIN_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO   = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1'b1);

    ctrl_state_e      state_r, state_nxt_s;
    logic [CNT_W-1:0] drain_cnt_r, drain_cnt_nxt_s;

    logic        wb_ex_r, wb_ex_nxt_s;
    logic        ertn_flush_r, ertn_flush_nxt_s;
    logic        pipe_flush_r, pipe_flush_nxt_s;
    logic        redirect_valid_r, redirect_valid_nxt_s;
    logic [31:0] redirect_pc_r, redirect_pc_nxt_s;
    logic [5:0]  ecode_r, ecode_nxt_s;
    logic [8:0]  esubcode_r, esubcode_nxt_s;
    logic [31:0] csr_pc_r, csr_pc_nxt_s;
    logic [31:0] vaddr_r, vaddr_nxt_s;

    logic        take_s;
    logic        is_ertn_s;
    logic [5:0]  ecode_s;
    logic [8:0]  esubcode_s;
    vaddr_sel_e  vaddr_sel_s;
    logic        run_s;
    logic        event_s;

    wb_ex_ctrl_prio_enc u_prio (
        .has_int   (has_int),
        .ex_adef   (wb_ex_adef),
        .ex_ine    (wb_ex_ine),
        .ex_sys    (wb_ex_sys),
        .ex_brk    (wb_ex_brk),
        .ex_ale    (wb_ex_ale),
        .ertn      (wb_ertn),
        .take      (take_s),
        .is_ertn   (is_ertn_s),
        .ecode     (ecode_s),
        .esubcode  (esubcode_s),
        .vaddr_sel (vaddr_sel_s)
    );

    // Flags and interrupts only count while running, so no event can nest.
    assign run_s     = (state_r == ST_RUN);
    assign event_s   = run_s & wb_valid & (take_s | is_ertn_s);
    assign commit_en = run_s & wb_valid & ~event_s;

    assign wb_ex          = wb_ex_r;
    assign ertn_flush     = ertn_flush_r;
    assign pipe_flush     = pipe_flush_r;
    assign redirect_valid = redirect_valid_r;
    assign redirect_pc    = redirect_pc_r;
    assign wb_ecode       = ecode_r;
    assign wb_esubcode    = esubcode_r;
    assign wb_csr_pc      = csr_pc_r;
    assign wb_vaddr       = vaddr_r;

    // Next-state and next-output logic; pulses default low, held values default to themselves.
    always_comb begin
        state_nxt_s          = state_r;
        drain_cnt_nxt_s      = drain_cnt_r;
        wb_ex_nxt_s          = 1'b0;
        ertn_flush_nxt_s     = 1'b0;
        pipe_flush_nxt_s     = 1'b0;
        redirect_valid_nxt_s = redirect_valid_r;
        redirect_pc_nxt_s    = redirect_pc_r;
        ecode_nxt_s          = ecode_r;
        esubcode_nxt_s       = esubcode_r;
        csr_pc_nxt_s         = csr_pc_r;
        vaddr_nxt_s          = vaddr_r;
        case (state_r)
            ST_RUN: begin
                if (event_s) begin
                    state_nxt_s          = ST_FLUSH;
                    wb_ex_nxt_s          = take_s;
                    ertn_flush_nxt_s     = is_ertn_s;
                    pipe_flush_nxt_s     = 1'b1;
                    redirect_valid_nxt_s = 1'b1;
                    redirect_pc_nxt_s    = take_s ? ex_entry : ertn_entry;
                    ecode_nxt_s          = ecode_s;
                    esubcode_nxt_s       = esubcode_s;
                    csr_pc_nxt_s         = wb_pc;
                    vaddr_nxt_s          = sel_vaddr(vaddr_sel_s, wb_pc, wb_vaddr_in);
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_FLUSH, ST_REDIR: begin
                if (redirect_ready) begin
                    redirect_valid_nxt_s = 1'b0;
                    if (DRAIN_CYCLES == 0) begin
                        state_nxt_s = ST_RUN;
                    end else begin
                        state_nxt_s     = ST_DRAIN;
                        drain_cnt_nxt_s = DRAIN_LOAD;
                    end
                end else begin
                    state_nxt_s = ST_REDIR;
                end
            end
            ST_DRAIN: begin
                if (drain_cnt_r == CNT_ZERO) begin
                    state_nxt_s = ST_RUN;
                end else begin
                    drain_cnt_nxt_s = drain_cnt_r - CNT_ONE;
                end
            end
            default: begin
                state_nxt_s          = ST_RUN;
                drain_cnt_nxt_s      = CNT_ZERO;
                redirect_valid_nxt_s = 1'b0;
            end
        endcase
    end

    // State, drain counter and all registered outputs.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r          <= ST_RUN;
            drain_cnt_r      <= CNT_ZERO;
            wb_ex_r          <= 1'b0;
            ertn_flush_r     <= 1'b0;
            pipe_flush_r     <= 1'b0;
            redirect_valid_r <= 1'b0;
            redirect_pc_r    <= 32'h0000_0000;
            ecode_r          <= 6'h00;
            esubcode_r       <= 9'h000;
            csr_pc_r         <= 32'h0000_0000;
            vaddr_r          <= 32'h0000_0000;
        end else begin
            state_r          <= state_nxt_s;
            drain_cnt_r      <= drain_cnt_nxt_s;
            wb_ex_r          <= wb_ex_nxt_s;
            ertn_flush_r     <= ertn_flush_nxt_s;
            pipe_flush_r     <= pipe_flush_nxt_s;
            redirect_valid_r <= redirect_valid_nxt_s;
            redirect_pc_r    <= redirect_pc_nxt_s;
            ecode_r          <= ecode_nxt_s;
            esubcode_r       <= esubcode_nxt_s;
            csr_pc_r         <= csr_pc_nxt_s;
            vaddr_r          <= vaddr_nxt_s;
        end
    end

endmodule

// File: tb/tb_wb_ex_ctrl.sv
// Directed self-checking bench for wb_ex_ctrl (DRAIN_CYCLES = 2).
module tb_wb_ex_ctrl;

    logic        clk;
    logic        resetn;
    logic        wb_valid;
    logic [31:0] wb_pc;
    logic [31:0] wb_vaddr_in;
    logic        wb_ex_adef, wb_ex_ine, wb_ex_sys, wb_ex_brk, wb_ex_ale, wb_ertn;
    logic        has_int;
    logic [31:0] ex_entry, ertn_entry;
    logic        commit_en, wb_ex, ertn_flush, pipe_flush, redirect_valid;
    logic [5:0]  wb_ecode;
    logic [8:0]  wb_esubcode;
    logic [31:0] wb_csr_pc, wb_vaddr, redirect_pc;
    logic        redirect_ready;

    int n_cmp = 0;
    int n_err = 0;

    wb_ex_ctrl #(.DRAIN_CYCLES(2)) dut (
        .clk            (clk),
        .resetn         (resetn),
        .wb_valid       (wb_valid),
        .wb_pc          (wb_pc),
        .wb_vaddr_in    (wb_vaddr_in),
        .wb_ex_adef     (wb_ex_adef),
        .wb_ex_ine      (wb_ex_ine),
        .wb_ex_sys      (wb_ex_sys),
        .wb_ex_brk      (wb_ex_brk),
        .wb_ex_ale      (wb_ex_ale),
        .wb_ertn        (wb_ertn),
        .has_int        (has_int),
        .ex_entry       (ex_entry),
        .ertn_entry     (ertn_entry),
        .commit_en      (commit_en),
        .wb_ex          (wb_ex),
        .ertn_flush     (ertn_flush),
        .wb_ecode       (wb_ecode),
        .wb_esubcode    (wb_esubcode),
        .wb_csr_pc      (wb_csr_pc),
        .wb_vaddr       (wb_vaddr),
        .pipe_flush     (pipe_flush),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .redirect_ready (redirect_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp_v);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wb_valid   = 1'b0;
        wb_ex_adef = 1'b0;
        wb_ex_ine  = 1'b0;
        wb_ex_sys  = 1'b0;
        wb_ex_brk  = 1'b0;
        wb_ex_ale  = 1'b0;
        wb_ertn    = 1'b0;
        has_int    = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".commit_en"}, 32'(commit_en), 32'h0);
        chk({tag, ".wb_ex"}, 32'(wb_ex), 32'h0);
        chk({tag, ".ertn_flush"}, 32'(ertn_flush), 32'h0);
        chk({tag, ".pipe_flush"}, 32'(pipe_flush), 32'h0);
        chk({tag, ".redirect_valid"}, 32'(redirect_valid), 32'h0);
        chk({tag, ".redirect_pc"}, redirect_pc, 32'h0);
        chk({tag, ".ecode"}, 32'(wb_ecode), 32'h0);
        chk({tag, ".esub"}, 32'(wb_esubcode), 32'h0);
        chk({tag, ".csr_pc"}, wb_csr_pc, 32'h0);
        chk({tag, ".vaddr"}, wb_vaddr, 32'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        resetn = 1'b0;
        idle();
        wb_pc = 32'h0;
        wb_vaddr_in = 32'h0;
        ex_entry = 32'h0;
        ertn_entry = 32'h0;
        redirect_ready = 1'b1;

        // Reset values
        step();
        step();
        chk_all_zero("reset");
        resetn = 1'b1;
        step();

        // Syscall, redirect accepted at once, then a 2-cycle drain
        wb_valid = 1'b1; wb_ex_sys = 1'b1; wb_pc = 32'h1c00_0100; ex_entry = 32'h1c00_8000;
        #1 chk("sys.commit_at_T", 32'(commit_en), 32'h0);
        step();
        idle();
        #1;
        chk("sys.wb_ex", 32'(wb_ex), 32'h1);
        chk("sys.ertn_flush", 32'(ertn_flush), 32'h0);
        chk("sys.pipe_flush", 32'(pipe_flush), 32'h1);
        chk("sys.ecode", 32'(wb_ecode), 32'h0B);
        chk("sys.esub", 32'(wb_esubcode), 32'h0);
        chk("sys.csr_pc", wb_csr_pc, 32'h1c00_0100);
        chk("sys.vaddr", wb_vaddr, 32'h0);
        chk("sys.rvalid", 32'(redirect_valid), 32'h1);
        chk("sys.rpc", redirect_pc, 32'h1c00_8000);
        step();
        wb_valid = 1'b1;
        #1;
        chk("sys.drain1.wb_ex", 32'(wb_ex), 32'h0);
        chk("sys.drain1.pipe_flush", 32'(pipe_flush), 32'h0);
        chk("sys.drain1.rvalid", 32'(redirect_valid), 32'h0);
        chk("sys.drain1.ecode_held", 32'(wb_ecode), 32'h0B);
        chk("sys.drain1.commit", 32'(commit_en), 32'h0);
        step();
        chk("sys.drain2.commit", 32'(commit_en), 32'h0);
        step();
        chk("sys.run.commit", 32'(commit_en), 32'h1);
        idle();

        // ALE + interrupt: interrupt wins, flags held during drain cause nothing
        wb_valid = 1'b1; wb_ex_ale = 1'b1; has_int = 1'b1;
        wb_pc = 32'h1c00_0200; wb_vaddr_in = 32'h0000_0003; ex_entry = 32'h1c00_9000;
        step();
        chk("int.wb_ex", 32'(wb_ex), 32'h1);
        chk("int.ecode", 32'(wb_ecode), 32'h00);
        chk("int.vaddr", wb_vaddr, 32'h0);
        chk("int.csr_pc", wb_csr_pc, 32'h1c00_0200);
        step();
        chk("int.no_second1", 32'(wb_ex), 32'h0);
        chk("int.commit_drain", 32'(commit_en), 32'h0);
        step();
        chk("int.no_second2", 32'(wb_ex), 32'h0);
        idle();
        step();
        chk("int.no_second3", 32'(wb_ex), 32'h0);
        chk("int.no_flush3", 32'(pipe_flush), 32'h0);

        // ertn
        wb_valid = 1'b1; wb_ertn = 1'b1; wb_pc = 32'h1c00_0300;
        ertn_entry = 32'h1c00_0104; ex_entry = 32'h1c00_8000;
        step();
        idle();
        #1;
        chk("ertn.flush", 32'(ertn_flush), 32'h1);
        chk("ertn.wb_ex", 32'(wb_ex), 32'h0);
        chk("ertn.pipe_flush", 32'(pipe_flush), 32'h1);
        chk("ertn.rpc", redirect_pc, 32'h1c00_0104);
        step();
        chk("ertn.flush_once", 32'(ertn_flush), 32'h0);
        step();
        step();

        // Break with redirect_ready low for 3 cycles
        redirect_ready = 1'b0;
        wb_valid = 1'b1; wb_ex_brk = 1'b1; wb_pc = 32'h1c00_0400; ex_entry = 32'h1c00_a000;
        step();
        idle();
        chk("hold.c1.ecode", 32'(wb_ecode), 32'h0C);
        chk("hold.c1.rvalid", 32'(redirect_valid), 32'h1);
        ex_entry = 32'h1234_5678;
        step();
        chk("hold.c2.rvalid", 32'(redirect_valid), 32'h1);
        chk("hold.c2.rpc", redirect_pc, 32'h1c00_a000);
        chk("hold.c2.wb_ex", 32'(wb_ex), 32'h0);
        step();
        chk("hold.c3.rvalid", 32'(redirect_valid), 32'h1);
        chk("hold.c3.rpc", redirect_pc, 32'h1c00_a000);
        step();
        redirect_ready = 1'b1;
        chk("hold.c4.rvalid", 32'(redirect_valid), 32'h1);
        chk("hold.c4.rpc", redirect_pc, 32'h1c00_a000);
        step();
        redirect_ready = 1'b0;
        wb_valid = 1'b1;
        #1;
        chk("hold.c5.rvalid", 32'(redirect_valid), 32'h0);
        chk("hold.c5.commit", 32'(commit_en), 32'h0);
        step();
        chk("hold.c6.commit", 32'(commit_en), 32'h0);
        step();
        chk("hold.c7.commit", 32'(commit_en), 32'h1);
        idle();
        redirect_ready = 1'b1;

        // ADEF beats INE
        wb_valid = 1'b1; wb_ex_adef = 1'b1; wb_ex_ine = 1'b1; wb_pc = 32'h1c00_0002;
        step();
        idle();
        chk("adef.ecode", 32'(wb_ecode), 32'h08);
        chk("adef.esub", 32'(wb_esubcode), 32'h0);
        chk("adef.vaddr", wb_vaddr, 32'h1c00_0002);
        step();
        step();
        step();

        // Interrupt pending without a valid instruction waits
        has_int = 1'b1;
        step();
        chk("intwait.no_ex", 32'(wb_ex), 32'h0);
        wb_valid = 1'b1;
        #1 chk("intwait.commit", 32'(commit_en), 32'h0);
        step();
        idle();
        chk("intwait.wb_ex", 32'(wb_ex), 32'h1);
        chk("intwait.ecode", 32'(wb_ecode), 32'h00);
        step();
        step();
        step();

        // Reset asserted while in REDIR
        redirect_ready = 1'b0;
        wb_valid = 1'b1; wb_ex_brk = 1'b1; wb_pc = 32'h1c00_0500; ex_entry = 32'h1c00_b000;
        step();
        idle();
        step();
        chk("rst.pre_rvalid", 32'(redirect_valid), 32'h1);
        resetn = 1'b0;
        #1;
        chk_all_zero("rst_redir");
        #1;
        resetn = 1'b1;
        redirect_ready = 1'b1;
        step();
        wb_valid = 1'b1; wb_pc = 32'h1c00_0600;
        #1 chk("rst.first_commit", 32'(commit_en), 32'h1);
        step();
        idle();
        chk("rst.no_pulse", 32'(wb_ex), 32'h0);
        chk("rst.no_redirect", 32'(redirect_valid), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
